lsu: RTL

- Load/store unit directly downstream of the ALU in the multi-step core.
- Consumes the ALU result as effective address, rs2 data as store data, and funct3 as access width/sign.
- Drives the word-addressed single-port RAM and returns the aligned, extended load value for register write-back.
- Sub-word stores use read-modify-write because the RAM has one write enable and no byte mask.

---
 rtl/frost_pkg.sv | 46 ++++
 rtl/lsu_if.sv | 44 ++++
 rtl/lsu_lane.sv | 48 ++++
 rtl/lsu.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/frost_pkg.sv
// -----------------------------------------------------------------------------
// frost_pkg
// Shared definitions for the load/store unit of the multi-step core.
//   - LSU_ADDR_W      : default RAM word-address width
//   - F3_B .. F3_HU   : RV32I load/store width codes (funct3)
//   - lsu_state_t     : LSU FSM state encoding
//   - f3_legal()      : is a funct3 legal for a load / for a store
//   - f3_misaligned() : does a byte offset violate the natural alignment
// -----------------------------------------------------------------------------
package frost_pkg;

    localparam int LSU_ADDR_W = 30;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_CAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } lsu_state_t;

    // Stores have no unsigned variants, so only B/H/W are legal for them.
    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        if (is_store) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_H, F3_HU: return off[0];
            F3_W:        return |off;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// -----------------------------------------------------------------------------
// lsu_if
// Bundles the LSU request/response signals and the RAM bus.
//   Request  : start, is_store, funct3[2:0], addr[31:0], wdata[31:0]
//   Response : busy, done, err, rdata[31:0]
//   RAM bus  : mem_addr[ADDR_W-1:0], mem_din[31:0], mem_re, mem_we, mem_dout[31:0]
// Modports: slave = the LSU, master = core + RAM side driving it.
//
// Handshake: a request is taken on a rising clk edge where start=1 and busy=0
// (LSU idle); start while busy=1 is dropped, never queued. The operation ends
// with a single-cycle done pulse (err qualifies it). RAM read data on mem_dout
// is valid in the cycle after mem_re; mem_we writes mem_din at the edge that
// ends its cycle.
// -----------------------------------------------------------------------------
interface lsu_if
    import frost_pkg::*;
#(
    parameter int ADDR_W = LSU_ADDR_W
) ();
    logic              start;
    logic              is_store;
    logic [2:0]        funct3;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [31:0]       rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_din;
    logic              mem_re;
    logic              mem_we;
    logic [31:0]       mem_dout;

    modport slave (
        input  start, is_store, funct3, addr, wdata, mem_dout,
        output busy, done, err, rdata, mem_addr, mem_din, mem_re, mem_we
    );

    modport master (
        output start, is_store, funct3, addr, wdata, mem_dout,
        input  busy, done, err, rdata, mem_addr, mem_din, mem_re, mem_we
    );
endinterface

// File: rtl/lsu_lane.sv
// -----------------------------------------------------------------------------
// lsu_lane
// Combinational lane logic for the LSU.
//   word_i   [31:0] : word read from RAM
//   off_i    [1:0]  : byte offset (addr[1:0])
//   funct3_i [2:0]  : access width / sign code
//   wdata_i  [31:0] : store data
//   load_o   [31:0] : selected lane, sign- or zero-extended
//   merge_o  [31:0] : word_i with the addressed lane replaced by store data
// Half accesses look only at off_i[1], word accesses ignore off_i entirely,
// which is what forces the low address bits to zero on misaligned accesses.
// -----------------------------------------------------------------------------
module lsu_lane
    import frost_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = word_i[{off_i, 3'b000} +: 8];
        half_v = off_i[1] ? word_i[31:16] : word_i[15:0];

        case (funct3_i)
            F3_B:    load_o = {{24{byte_v[7]}}, byte_v};
            F3_BU:   load_o = {24'd0, byte_v};
            F3_H:    load_o = {{16{half_v[15]}}, half_v};
            F3_HU:   load_o = {16'd0, half_v};
            default: load_o = word_i;
        endcase

        merge_o = word_i;
        case (funct3_i)
            F3_B: merge_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
            F3_H: begin
                if (off_i[1]) merge_o[31:16] = wdata_i[15:0];
                else          merge_o[15:0]  = wdata_i[15:0];
            end
            default: merge_o = wdata_i;
        endcase
    end
endmodule

// File: rtl/lsu.sv
// -----------------------------------------------------------------------------
// lsu
// Load/store unit between the ALU and a word-addressed single-port RAM.
// Sub-word stores use read-modify-write since the RAM has no byte mask.
//   clk          : core clock
//   rst_n        : synchronous active-low reset
//   bus          : lsu_if.slave (request, response and RAM bus)
//   dbg_state_o  : current FSM state, for observation only
// Configuration macro: LSU_MISALIGN_TRAP_EN
//   defined   -> misaligned half/word accesses complete with err, no RAM access
//   undefined -> low address bits are ignored and the access proceeds
// All outputs are registered inside the single FSM process.
// -----------------------------------------------------------------------------
module lsu
    import frost_pkg::*;
#(
    parameter int ADDR_W = LSU_ADDR_W
) (
    input  logic       clk,
    input  logic       rst_n,
    lsu_if.slave       bus,
    output lsu_state_t dbg_state_o
);
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit MISALIGN_TRAP = 1'b1;
`else
    localparam bit MISALIGN_TRAP = 1'b0;
`endif

    lsu_state_t        state_q;
    logic              is_store_q;
    logic [2:0]        funct3_q;
    logic [1:0]        off_q;
    logic [31:0]       wdata_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic [31:0]       rdata_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_din_q;
    logic              mem_re_q;
    logic              mem_we_q;

    logic              trap;
    logic [31:0]       lane_load;
    logic [31:0]       lane_merge;

    always_comb begin
        trap = !f3_legal(bus.is_store, bus.funct3) ||
               (MISALIGN_TRAP && f3_misaligned(bus.funct3, bus.addr[1:0]));
    end

    // mem_dout is only meaningful in CAP, which is the only state that
    // consumes the lane outputs.
    lsu_lane u_lane (
        .word_i   (bus.mem_dout),
        .off_i    (off_q),
        .funct3_i (funct3_q),
        .wdata_i  (wdata_q),
        .load_o   (lane_load),
        .merge_o  (lane_merge)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            is_store_q <= 1'b0;
            funct3_q   <= 3'd0;
            off_q      <= 2'd0;
            wdata_q    <= 32'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= 32'd0;
            mem_addr_q <= '0;
            mem_din_q  <= 32'd0;
            mem_re_q   <= 1'b0;
            mem_we_q   <= 1'b0;
        end else begin
            // Pulsed outputs default low every cycle.
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            mem_re_q <= 1'b0;
            mem_we_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        is_store_q <= bus.is_store;
                        funct3_q   <= bus.funct3;
                        off_q      <= bus.addr[1:0];
                        wdata_q    <= bus.wdata;
                        mem_addr_q <= bus.addr[ADDR_W+1:2];
                        busy_q     <= 1'b1;
                        if (trap) begin
                            state_q <= ST_ERR;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else if (bus.is_store && (bus.funct3 == F3_W)) begin
                            // Full-word store needs no read.
                            state_q   <= ST_WR;
                            mem_we_q  <= 1'b1;
                            mem_din_q <= bus.wdata;
                        end else begin
                            state_q  <= ST_REQ;
                            mem_re_q <= 1'b1;
                        end
                    end
                end

                ST_REQ: begin
                    state_q <= ST_CAP;
                end

                ST_CAP: begin
                    if (is_store_q) begin
                        state_q   <= ST_WR;
                        mem_we_q  <= 1'b1;
                        mem_din_q <= lane_merge;
                    end else begin
                        state_q <= ST_DONE;
                        rdata_q <= lane_load;
                        done_q  <= 1'b1;
                    end
                end

                ST_WR: begin
                    state_q <= ST_DONE;
                    done_q  <= 1'b1;
                end

                default: begin
                    // DONE, ERR and any unused encoding fall back to IDLE.
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.rdata    = rdata_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_din  = mem_din_q;
    assign bus.mem_re   = mem_re_q;
    assign bus.mem_we   = mem_we_q;
    assign dbg_state_o  = state_q;

endmodule
